// File: rtl/aes_pkg.sv
// Shared AES-128 primitives for the encrypt and decrypt datapaths:
// forward S-box, round constants, GF(2^8) helpers and the iterative FSM states.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  localparam int unsigned AES128_ROUNDS = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// AES-128 key schedule step: round key plus rcon to the next round key.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rc,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  assign n0 = w0 ^ sub ^ {rc, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per cycle on a single round datapath.
// Latency: 10 cycles accept to out_valid; one block per 12 cycles back-to-back.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_out,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  aes_fsm_e     fsm_q, fsm_d;
  logic [127:0] state_q, rk_q, cipher_q;
  logic [3:0]   round_q;

  logic [127:0] sb, sr, mc, rk_next, round_out;
  logic [7:0]   round_rc;
  logic         last_round;

  assign round_rc   = rcon(round_q);
  assign last_round = (round_q == LAST_ROUND);

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rc      (round_rc),
    .rk_next (rk_next)
  );

  // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
  end

  assign round_out = (last_round ? sr : mc) ^ rk_next;

  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= ST_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid) fsm_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_round) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= '0;
      rk_q     <= '0;
      round_q  <= '0;
      cipher_q <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= plain_in ^ key_in;
            rk_q    <= key_in;
            round_q <= 4'd1;
          end
        end
        ST_RUN: begin
          state_q <= round_out;
          rk_q    <= rk_next;
          // Counter parks on the last round so it never leaves 1..10.
          if (last_round) cipher_q <= round_out;
          else            round_q  <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign cipher_out = cipher_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: known-answer vectors, backpressure, back-to-back,
// reset abort and random jobs checked against a table-free AES model.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plain_in = '0;
  logic [127:0] key_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] cipher_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb_t  [256];
  logic [7:0] isb_t [256];

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plain_in   (plain_in),
    .key_in     (key_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cipher_out (cipher_out),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from the field inverse and affine map, not from a table.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb_t[x]  = s;
      isb_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
        t  = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] v;
    v = pt ^ round_key(key, 0);
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w + 4*((c+w)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          for (int w = 0; w < 4; w++)
            s[4*c+w] = gmul(8'h02, a[w]) ^ gmul(8'h03, a[(w+1)%4]) ^ a[(w+2)%4] ^ a[(w+3)%4];
        end
      v = round_key(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ v[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] v;
    v = ct ^ round_key(key, 10);
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = s[w + 4*((c-w+4)%4)];
      for (int i = 0; i < 16; i++) s[i] = isb_t[t[i]];
      v = round_key(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ v[127-8*i -: 8];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          for (int w = 0; w < 4; w++)
            s[4*c+w] = gmul(8'h0e, a[w]) ^ gmul(8'h0b, a[(w+1)%4]) ^
                       gmul(8'h0d, a[(w+2)%4]) ^ gmul(8'h09, a[(w+3)%4]);
        end
    end
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  // ---------------- stimulus helpers (entered and left on a negedge) ----------------
  task automatic offer(input logic [127:0] k, input logic [127:0] p, input bit hold, output time acc_t);
    int n;
    in_valid = 1'b1;
    key_in   = k;
    plain_in = p;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc_t = $time + 5;
    if (!in_ready) begin
      check("accept_timeout", {127'b0, in_ready}, 128'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output time vld_t);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_timeout", {127'b0, out_valid}, 128'd1);
    vld_t = $time - 5;
  endtask

  task automatic take_out(input int stall);
    logic [127:0] held;
    held = cipher_out;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_stable", cipher_out, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_hs", {127'b0, in_ready}, 128'd1);
    check("ovld_drop", {127'b0, out_valid}, 128'd0);
    check("cipher_kept", cipher_out, held);
  endtask

  task automatic run_job(input logic [127:0] k, input logic [127:0] p, input int stall,
                         output logic [127:0] ct);
    time ta, tv;
    offer(k, p, 1'b0, ta);
    wait_out(tv);
    check("latency", 128'((tv - ta) / 10), 128'd10);
    ct = cipher_out;
    take_out(stall);
  endtask

  // ---------------- main sequence ----------------
  time          ta, tb_t, tv;
  logic [127:0] ct, held, k, p;
  int           seen;

  initial begin
    build_sbox();

    repeat (2) @(negedge clk);
    check("rst_in_ready", {127'b0, in_ready}, 128'd0);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_cipher", cipher_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

    run_job(K_C1, P_C1, 0, ct);
    check("fips_c1", ct, C_C1);

    // Backpressure on the appendix-B vector with ignored in_valid pulses.
    offer(K_B, P_B, 1'b0, ta);
    wait_out(tv);
    check("bp_latency", 128'((tv - ta) / 10), 128'd10);
    check("fips_b", cipher_out, C_B);
    held = cipher_out;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      plain_in = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_stable", cipher_out, held);
      check("bp_in_ready", {127'b0, in_ready}, 128'd0);
      check("bp_out_valid", {127'b0, out_valid}, 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle", {127'b0, in_ready}, 128'd1);
    check("bp_busy", {127'b0, busy}, 128'd0);
    check("bp_kept", cipher_out, held);

    // Back-to-back with in_valid held across both jobs.
    out_ready = 1'b1;
    offer(K_C1, P_C1, 1'b1, ta);
    key_in   = K_B;
    plain_in = P_B;
    wait_out(tv);
    check("b2b_first", cipher_out, C_C1);
    offer(K_B, P_B, 1'b0, tb_t);
    check("b2b_spacing", 128'((tb_t - ta) / 10), 128'd12);
    wait_out(tv);
    check("b2b_second", cipher_out, C_B);
    check("b2b_latency", 128'((tv - tb_t) / 10), 128'd10);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while the job sits at round 5.
    offer(K_C1, P_C1, 1'b0, ta);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cipher", cipher_out, 128'd0);
    check("abort_out_valid", {127'b0, out_valid}, 128'd0);
    check("abort_busy", {127'b0, busy}, 128'd0);
    check("abort_in_ready", {127'b0, in_ready}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_ovld", 128'(seen), 128'd0);
    run_job(K_C1, P_C1, 1, ct);
    check("after_abort_c1", ct, C_C1);

    for (int j = 0; j < 6; j++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_job(k, p, int'($urandom_range(0, 3)), ct);
      check("rand_cipher", ct, ref_encrypt(k, p));
    end

    for (int j = 0; j < 4; j++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      run_job(K_B, p, int'($urandom_range(0, 2)), ct);
      check("round_trip", ref_decrypt(K_B, ct), p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks so far %0d)", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter: ROUNDS, 10, AES-128 round count (only value supported).
REQ-002 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  plaintext/key offered.
REQ-005 SHALL have port: in_ready  output  1  block idle, accepts new job.
REQ-006 SHALL have port: plain_in  input  128  plaintext, bits [127:120] = FIPS-197 byte 0 (column-major state).
REQ-007 SHALL have port: key_in  input  128  cipher key, same byte order.
REQ-008 SHALL have port: out_valid  output  1  ciphertext available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts ciphertext.
REQ-010 SHALL have port: cipher_out  output  128  ciphertext, same byte order.
REQ-011 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FIPS-197 AES-128 encryption, the inverse of the team's unrolled decrypt datapath: initial AddRoundKey; rounds 1..9 SubBytes, ShiftRows, MixColumns, AddRoundKey; round 10 without MixColumns.
REQ-013 SHALL use an FSM with states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE, drive in_ready=1; on in_valid&in_ready, register state<=plain_in^key_in, rk<=key_in, round<=1, go to RUN.
REQ-015 SHALL, in RUN, execute one round per cycle: compute next round key from rk and rcon[round], apply round to state, increment round.
REQ-016 SHALL, when round 10 completes, load cipher_out and enter DONE; accept-to-out_valid latency exactly 10 cycles.
REQ-017 SHALL, in DONE, hold out_valid=1 and cipher_out stable until out_valid&out_ready, then return to IDLE.
REQ-018 SHALL drive in_ready=0 in RUN and DONE; in_valid there is ignored, plain_in/key_in sampled only at acceptance.
REQ-019 SHALL permit back-to-back jobs: out_ready high in DONE gives IDLE next cycle; throughput one block per 12 cycles.
REQ-020 SHALL keep cipher_out at its last value after handshake; valid only when out_valid=1.
REQ-021 SHALL use a 4-bit round counter; values 0 and 11..15 unreachable; an illegal FSM encoding recovers to IDLE.
REQ-022 SHALL compute rcon as 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.

Reset
REQ-023 SHALL on rst_n=0 at a clk edge set FSM=IDLE, round=0, state=0, rk=0, cipher_out=0, out_valid=0, busy=0.
REQ-024 SHALL drive in_ready=0 while rst_n=0, 1 in the first cycle after release.
REQ-025 SHALL abort an in-flight job on reset mid-RUN or mid-DONE with no out_valid pulse.

Structure
REQ-026 SHALL place S-box table, rcon table, xtime/MixColumns helpers and the FSM state enum in shared package aes_pkg, reused by decrypt logic.
REQ-027 SHALL instantiate one sub-module aes_key_step (combinational: rk, rcon -> next rk); all other round logic inline.
REQ-028 SHALL contain 16 S-box instances for state plus 4 inside aes_key_step; no unrolled round stages.

Verification
REQ-029 SHALL pass FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff -> cipher 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
REQ-030 SHALL pass FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plain 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-031 SHALL test backpressure: out_ready=0 for 20 cycles after out_valid -> cipher_out stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-032 SHALL test back-to-back: both vectors offered with in_valid held, out_ready=1 -> two correct ciphertexts, accepts 12 cycles apart.
REQ-033 SHALL test reset mid-RUN at round 5 -> all outputs zero, no out_valid, next job (C.1) correct.
REQ-034 SHALL test round-trip: encrypt random plaintexts with the decrypt datapath's fixed key, feed to decrypt -> original plaintext recovered.
